axi_lite_kernel_ctrl: RTL and testbench

Parametrised AXI4-Lite control slave for kernel tops: register file holding start/done/idle status, an interrupt block and `ARG_WORDS` 32-bit argument words. The argument words are exported as a flat vector that the top slices into 64-bit memory-port base pointers.
- Extends the plain control slave with:
  - auto-restart;
  - ap_ready reporting;
  - per-source interrupt enable/status;
  - byte-strobed argument writes.
- Sits between the host AXI-Lite `s_axi_control` port and the processor's start/done/idle handshake.

---
 rtl/axi_lite_kernel_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_axi_lite_kernel_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_kernel_ctrl.sv
// AXI4-Lite control slave for a kernel: CTRL start/done/idle/ready, optional interrupt block
// (build with KERNEL_CTRL_IRQ_EN) and ARG_WORDS byte-strobed 32-bit argument registers.
module axi_lite_kernel_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ARG_WORDS  = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    s_axi_AWVALID,
  output logic                    s_axi_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
  input  logic                    s_axi_WVALID,
  output logic                    s_axi_WREADY,
  input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
  input  logic [3:0]              s_axi_WSTRB,
  output logic                    s_axi_BVALID,
  input  logic                    s_axi_BREADY,
  output logic [1:0]              s_axi_BRESP,
  input  logic                    s_axi_ARVALID,
  output logic                    s_axi_ARREADY,
  input  logic [ADDR_WIDTH-1:0]   s_axi_ARADDR,
  output logic                    s_axi_RVALID,
  input  logic                    s_axi_RREADY,
  output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
  output logic [1:0]              s_axi_RRESP,
  output logic                    start,
  input  logic                    done,
  input  logic                    idle,
  output logic [32*ARG_WORDS-1:0] args,
  output logic                    interrupt,
  output logic [1:0]              dbg_state_o
);
  // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
  // valid, once raised, holds with stable payload until that edge.
  localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
  localparam int WA = ADDR_WIDTH - 2;
  localparam logic [WA-1:0] A_CTRL = WA'(0), A_GIE = WA'(1), A_IER = WA'(2), A_ISR = WA'(3);

  logic [0:0]  w_state_q, w_state_d, r_state_q, r_state_d;
  logic        rst_done_q;
  logic [31:0] rdata_q, rdata_d, rdata_mux;
  logic        ap_start_q, ap_start_d, ap_done_q, ap_done_d;
  logic        ap_ready_q, ap_ready_d, auto_restart_q, auto_restart_d;
  logic [31:0] args_q [ARG_WORDS];
  logic [31:0] args_d [ARG_WORDS];
  logic [31:0] gie_rd, ier_rd, isr_rd;
  logic [WA-1:0] waddr, raddr;
  logic        wr_hs, rd_hs, wr_ctrl, rd_ctrl, start_hs;
  logic        unused_addr_lsbs;

  assign waddr    = s_axi_AWADDR[ADDR_WIDTH-1:2];
  assign raddr    = s_axi_ARADDR[ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = ^{s_axi_AWADDR[1:0], s_axi_ARADDR[1:0]};

  assign s_axi_AWREADY = (w_state_q == W_IDLE) & rst_done_q & s_axi_AWVALID & s_axi_WVALID;
  assign s_axi_WREADY  = s_axi_AWREADY;
  assign s_axi_BVALID  = (w_state_q == W_RESP);
  assign s_axi_BRESP   = 2'b00;
  assign s_axi_ARREADY = (r_state_q == R_IDLE) & rst_done_q;
  assign s_axi_RVALID  = (r_state_q == R_DATA);
  assign s_axi_RDATA   = rdata_q;
  assign s_axi_RRESP   = 2'b00;
  assign dbg_state_o   = {w_state_q, r_state_q};

  assign wr_hs    = s_axi_AWREADY;
  assign rd_hs    = s_axi_ARREADY & s_axi_ARVALID;
  assign wr_ctrl  = wr_hs & (waddr == A_CTRL) & s_axi_WSTRB[0];
  assign rd_ctrl  = rd_hs & (raddr == A_CTRL);
  assign start_hs = ap_start_q & idle;
  assign start    = ap_start_q;

  // Sticky bits: a set in the same cycle as a clearing read wins.
  always_comb begin
    ap_start_d = ap_start_q;
    if (start_hs && !auto_restart_q) ap_start_d = 1'b0;
    if (wr_ctrl && s_axi_WDATA[0])   ap_start_d = 1'b1;
    auto_restart_d = wr_ctrl ? s_axi_WDATA[7] : auto_restart_q;
    ap_done_d  = done | (ap_done_q & ~rd_ctrl);
    ap_ready_d = start_hs | (ap_ready_q & ~rd_ctrl);
  end

  always_comb begin
    for (int k = 0; k < ARG_WORDS; k++) begin
      args_d[k] = args_q[k];
      if (wr_hs && waddr == WA'(4 + k))
        for (int b = 0; b < 4; b++)
          if (s_axi_WSTRB[b]) args_d[k][8*b +: 8] = s_axi_WDATA[8*b +: 8];
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (raddr)
      A_CTRL:  rdata_mux = {24'b0, auto_restart_q, 3'b0, ap_ready_q, idle, ap_done_q, ap_start_q};
      A_GIE:   rdata_mux = gie_rd;
      A_IER:   rdata_mux = ier_rd;
      A_ISR:   rdata_mux = isr_rd;
      default: rdata_mux = '0;
    endcase
    for (int k = 0; k < ARG_WORDS; k++)
      if (raddr == WA'(4 + k)) rdata_mux = args_q[k];
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (wr_hs) w_state_d = W_RESP;
      default: if (s_axi_BREADY) w_state_d = W_IDLE;
    endcase
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE:  if (rd_hs) begin r_state_d = R_DATA; rdata_d = rdata_mux; end
      default: if (s_axi_RREADY) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      w_state_q      <= W_IDLE;
      r_state_q      <= R_IDLE;
      rst_done_q     <= 1'b0;
      rdata_q        <= '0;
      ap_start_q     <= 1'b0;
      ap_done_q      <= 1'b0;
      ap_ready_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      for (int k = 0; k < ARG_WORDS; k++) args_q[k] <= '0;
    end else begin
      w_state_q      <= w_state_d;
      r_state_q      <= r_state_d;
      rst_done_q     <= 1'b1;
      rdata_q        <= rdata_d;
      ap_start_q     <= ap_start_d;
      ap_done_q      <= ap_done_d;
      ap_ready_q     <= ap_ready_d;
      auto_restart_q <= auto_restart_d;
      for (int k = 0; k < ARG_WORDS; k++) args_q[k] <= args_d[k];
    end
  end

  for (genvar g = 0; g < ARG_WORDS; g++) begin : g_args
    assign args[32*g +: 32] = args_q[g];
  end

`ifdef KERNEL_CTRL_IRQ_EN
  logic       gie_q, gie_d, irq_q;
  logic [1:0] ier_q, ier_d, isr_q, isr_d;

  // ISR is write-1-to-toggle; a hardware set in the same cycle overrides the toggle.
  always_comb begin
    gie_d = gie_q;
    ier_d = ier_q;
    isr_d = isr_q;
    if (wr_hs && s_axi_WSTRB[0]) begin
      if (waddr == A_GIE) gie_d = s_axi_WDATA[0];
      if (waddr == A_IER) ier_d = s_axi_WDATA[1:0];
      if (waddr == A_ISR) isr_d = isr_q ^ s_axi_WDATA[1:0];
    end
    isr_d = isr_d | {start_hs & ier_q[1], done & ier_q[0]};
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      gie_q <= 1'b0;
      ier_q <= 2'b0;
      isr_q <= 2'b0;
      irq_q <= 1'b0;
    end else begin
      gie_q <= gie_d;
      ier_q <= ier_d;
      isr_q <= isr_d;
      irq_q <= gie_q & (|isr_q);
    end
  end

  assign interrupt = irq_q;
  assign gie_rd    = {31'b0, gie_q};
  assign ier_rd    = {30'b0, ier_q};
  assign isr_rd    = {30'b0, isr_q};
`else
  assign interrupt = 1'b0;
  assign gie_rd    = '0;
  assign ier_rd    = '0;
  assign isr_rd    = '0;
`endif

endmodule

// File: tb/tb_axi_lite_kernel_ctrl.sv
// Directed bench for axi_lite_kernel_ctrl: read expectations queued at AR issue, checked at R.
module tb_axi_lite_kernel_ctrl;
  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [7:0]   AWADDR = '0, ARADDR = '0;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]   BRESP, RRESP, dbg_state;
  logic [31:0]  RDATA;
  logic         start, done = 0, idle = 1, interrupt;
  logic [127:0] args;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_kernel_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ARG_WORDS(4)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axi_AWVALID(AWVALID), .s_axi_AWREADY(AWREADY), .s_axi_AWADDR(AWADDR),
    .s_axi_WVALID(WVALID), .s_axi_WREADY(WREADY), .s_axi_WDATA(WDATA), .s_axi_WSTRB(WSTRB),
    .s_axi_BVALID(BVALID), .s_axi_BREADY(BREADY), .s_axi_BRESP(BRESP),
    .s_axi_ARVALID(ARVALID), .s_axi_ARREADY(ARREADY), .s_axi_ARADDR(ARADDR),
    .s_axi_RVALID(RVALID), .s_axi_RREADY(RREADY), .s_axi_RDATA(RDATA), .s_axi_RRESP(RRESP),
    .start(start), .done(done), .idle(idle), .args(args), .interrupt(interrupt),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected end before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // driver tasks
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
    #1;
    while (!(AWREADY && WREADY) && t < 20) begin tick(); t++; end
    check("aw_w_ready", {31'b0, AWREADY & WREADY}, 32'h1);
    tick();
    AWVALID = 0; WVALID = 0;
    check("bvalid", {31'b0, BVALID}, 32'h1);
    check("bresp", {30'b0, BRESP}, 32'h0);
    BREADY = 1;
    tick();
    BREADY = 0;
  endtask

  task automatic ar_issue(input logic [7:0] a, input logic [31:0] exp);
    int t = 0;
    exp_q.push_back(exp);
    ARADDR = a; ARVALID = 1;
    #1;
    while (!ARREADY && t < 20) begin tick(); t++; end
    check("arready", {31'b0, ARREADY}, 32'h1);
    tick();
    ARVALID = 0;
  endtask

  task automatic r_collect(input string tag);
    int t = 0;
    logic [31:0] exp;
    while (!RVALID && t < 20) begin tick(); t++; end
    check({tag, "_rvalid"}, {31'b0, RVALID}, 32'h1);
    exp = exp_q.pop_front();
    check(tag, RDATA, exp);
    check({tag, "_rresp"}, {30'b0, RRESP}, 32'h0);
    RREADY = 1;
    tick();
    RREADY = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    ar_issue(a, exp);
    r_collect(tag);
  endtask

  task automatic pulse_done();
    done = 1;
    tick();
    done = 0;
  endtask

  initial begin
    // reset
    repeat (3) tick();
    check("rst_arready", {31'b0, ARREADY}, 32'h0);
    check("rst_rdata", RDATA, 32'h0);
    ap_rst = 0;
    tick();
    check("rst_start", {31'b0, start}, 32'h0);
    check("rst_irq", {31'b0, interrupt}, 32'h0);
    check("rst_args", {31'b0, args === 128'h0}, 32'h1);
    check("rst_bvalid", {31'b0, BVALID}, 32'h0);
    check("rst_rvalid", {31'b0, RVALID}, 32'h0);
    axi_read(8'h00, 32'h4, "ctrl_rst");

    // byte-strobed argument writes
    axi_write(8'h10, 32'hDEADBEEF, 4'b0011);
    axi_read(8'h10, 32'h0000BEEF, "arg0");
    check("args0", args[31:0], 32'h0000BEEF);
    axi_write(8'h17, 32'h12345678, 4'b1100);
    axi_read(8'h14, 32'h12340000, "arg1");
    check("args1", args[63:32], 32'h12340000);

    // single start handshake
    idle = 0;
    axi_write(8'h00, 32'h1, 4'hF);
    check("start_hi", {31'b0, start}, 32'h1);
    axi_read(8'h00, 32'h1, "ctrl_busy");
    idle = 1;
    #1;
    check("start_before_hs", {31'b0, start}, 32'h1);
    tick();
    check("start_cleared", {31'b0, start}, 32'h0);
    axi_read(8'h00, 32'hC, "ctrl_ready");
    axi_read(8'h00, 32'h4, "ctrl_ready_clr");

    // auto restart
    axi_write(8'h00, 32'h81, 4'hF);
    repeat (3) tick();
    check("auto_start", {31'b0, start}, 32'h1);
    pulse_done();
    tick();
    pulse_done();
    check("auto_start2", {31'b0, start}, 32'h1);
    axi_read(8'h00, 32'h8F, "ctrl_auto_done");
    axi_read(8'h00, 32'h8D, "ctrl_auto_done_clr");
    axi_write(8'h00, 32'h00, 4'hF);
    check("auto_stop", {31'b0, start}, 32'h0);
    axi_read(8'h00, 32'hC, "ctrl_stop");
    axi_read(8'h00, 32'h4, "ctrl_stop_clr");

    // done pulse on the same edge as a clearing read
    done = 1;
    ar_issue(8'h00, 32'h4);
    done = 0;
    r_collect("ctrl_race_old");
    axi_read(8'h00, 32'h6, "ctrl_race_kept");
    axi_read(8'h00, 32'h4, "ctrl_race_clr");

    // RREADY back-pressure with a done pulse during the stall
    ar_issue(8'h00, 32'h4);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) done = 1;
      tick();
      done = 0;
      check("hold_rvalid", {31'b0, RVALID}, 32'h1);
      check("hold_rdata", RDATA, 32'h4);
    end
    r_collect("ctrl_hold");
    axi_read(8'h00, 32'h6, "ctrl_after_hold");

    // unmapped address
    axi_write(8'h20, 32'hFFFFFFFF, 4'hF);
    axi_read(8'h20, 32'h0, "unmapped");
    axi_read(8'h10, 32'h0000BEEF, "arg0_intact");

`ifdef KERNEL_CTRL_IRQ_EN
    axi_write(8'h04, 32'h1, 4'hF);
    axi_write(8'h08, 32'h1, 4'hF);
    axi_read(8'h04, 32'h1, "gie");
    axi_read(8'h08, 32'h1, "ier");
    pulse_done();
    check("irq_lag", {31'b0, interrupt}, 32'h0);
    tick();
    check("irq_set", {31'b0, interrupt}, 32'h1);
    axi_read(8'h0C, 32'h1, "isr");
    axi_write(8'h0C, 32'h1, 4'hF);
    check("irq_clr", {31'b0, interrupt}, 32'h0);
    axi_read(8'h0C, 32'h0, "isr_clr");
`else
    axi_write(8'h04, 32'h1, 4'hF);
    axi_write(8'h08, 32'h3, 4'hF);
    axi_read(8'h04, 32'h0, "gie_absent");
    axi_read(8'h08, 32'h0, "ier_absent");
    pulse_done();
    tick();
    check("irq_tied", {31'b0, interrupt}, 32'h0);
`endif

    check("sb_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
